// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types for the common data bus (CDB) arbiter and its users.
//   cond_exception_t : CR0 / XER condition and exception bits carried with a result
//   cdb_entry_t      : one CDB broadcast entry (RS ID, GPR address, result, bits)
//   count_ones       : population count of an up-to-8-bit request vector
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  // RS IDs are stored at this fixed width; narrower IDs occupy the low bits.
  localparam int RS_ID_MAX_WIDTH = 8;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
  } cond_exception_t;

  typedef struct packed {
    logic [0:RS_ID_MAX_WIDTH-1] rs_id;
    logic [0:4]                 reg_addr;
    logic [0:31]                result;
    cond_exception_t            cr0_xer;
  } cdb_entry_t;

  function automatic int unsigned count_ones(input logic [7:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search begins at `pointer`
// and wraps N-1 -> 0; the first set request wins.
//   req     in  [N-1:0]          request bits, bit i = requester i
//   pointer in  [$clog2(N)-1:0]  highest-priority requester this cycle
//   grant   out [N-1:0]          one-hot grant (all zero when no request)
//   idx     out [$clog2(N)-1:0]  index of the granted requester (0 when none)
//   any     out                  at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic [W-1:0] cand_s;

  // Walk the requesters in rotated priority order and take the first one found.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = W'((32'(pointer) + k) % N);
      if (!any && req[cand_s]) begin
        any           = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Grants one execution-unit result per cycle, round-robin, into a single
// registered CDB output stage that feeds the reservation stations and commit.
//   clk, rst       clock; synchronous active-high reset
//   unit_valid     per-unit result available
//   unit_ready     per-unit result accepted this cycle (combinational)
//   unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer : per-unit payload
//   cdb_valid/cdb_ready : broadcast handshake
//   cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_unit : broadcast payload
// Optional feature, macro CDB_PERF_CNT_EN: adds perf_grants (transfers) and
// perf_conflicts (load cycles with two or more requesters), both 32-bit wrapping.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [0:UNITS-1]                      unit_valid,
  output logic [0:UNITS-1]                      unit_ready,
  input  logic [0:UNITS-1][0:RS_ID_WIDTH-1]     unit_rs_id,
  input  logic [0:UNITS-1][0:4]                 unit_reg_addr,
  input  logic [0:UNITS-1][0:31]                unit_result,
  input  cond_exception_t [0:UNITS-1]           unit_cr0_xer,
  output logic                                  cdb_valid,
  input  logic                                  cdb_ready,
  output logic [0:RS_ID_WIDTH-1]                cdb_rs_id,
  output logic [0:4]                            cdb_reg_addr,
  output logic [0:31]                           cdb_result,
  output cond_exception_t                       cdb_cr0_xer,
  output logic [$clog2(UNITS)-1:0]              cdb_unit
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_grants,
  output logic [31:0]                           perf_conflicts
`endif
);

  localparam int IDX_W = $clog2(UNITS);

  logic [UNITS-1:0] req_s;
  logic [UNITS-1:0] grant_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             any_s;
  logic             load_s;
  logic             xfer_s;

  logic             cdb_valid_q, cdb_valid_d;
  cdb_entry_t       entry_q, entry_d;
  logic [IDX_W-1:0] unit_q, unit_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Re-index the ascending port vector so bit i of req_s is unit i.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < UNITS; i++) begin
      req_s[i] = unit_valid[i];
    end
  end

  rr_arbiter #(.N(UNITS)) u_rr (
    .req     (req_s),
    .pointer (ptr_q),
    .grant   (grant_s),
    .idx     (win_idx_s),
    .any     (any_s)
  );

  // Load when the output stage is empty or draining; ready is withheld in reset.
  always_comb begin
    load_s     = !cdb_valid_q || cdb_ready;
    xfer_s     = load_s && any_s && !rst;
    unit_ready = '0;
    for (int i = 0; i < UNITS; i++) begin
      unit_ready[i] = grant_s[i] && load_s && !rst;
    end
  end

  // Next state of the output stage and round-robin pointer.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    entry_d     = entry_q;
    unit_d      = unit_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      cdb_valid_d      = 1'b1;
      unit_d           = win_idx_s;
      entry_d.rs_id    = RS_ID_MAX_WIDTH'(unit_rs_id[win_idx_s]);
      entry_d.reg_addr = unit_reg_addr[win_idx_s];
      entry_d.result   = unit_result[win_idx_s];
      entry_d.cr0_xer  = unit_cr0_xer[win_idx_s];
      if (win_idx_s == IDX_W'(UNITS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx_s + IDX_W'(1);
      end
    end else if (load_s) begin
      // Drained (or already empty) with nothing new to load.
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // Output stage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      entry_q     <= '0;
      unit_q      <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      entry_q     <= entry_d;
      unit_q      <= unit_d;
      ptr_q       <= ptr_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rs_id    = RS_ID_WIDTH'(entry_q.rs_id);
  assign cdb_reg_addr = entry_q.reg_addr;
  assign cdb_result   = entry_q.result;
  assign cdb_cr0_xer  = entry_q.cr0_xer;
  assign cdb_unit     = unit_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;
  logic        conflict_s;

  // Event counters; both wrap naturally at 2^32.
  always_comb begin
    conflict_s       = load_s && !rst && (count_ones(8'(req_s)) >= 32'd2);
    perf_grants_d    = perf_grants_q + (xfer_s ? 32'd1 : 32'd0);
    perf_conflicts_d = perf_conflicts_q + (conflict_s ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants_q    <= 32'd0;
      perf_conflicts_q <= 32'd0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed, table-driven bench for cdb_arbiter (UNITS=4, RS_ID_WIDTH=5).
// Each unit carries a fixed payload; every table row gives the inputs for one
// cycle and the expected grant plus the expected registered CDB state seen in
// that cycle. Hand-written sequences cover starvation and the perf counters
// (perf counters only when CDB_PERF_CNT_EN is defined).
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int UNITS = 4;
  localparam int RSW   = 5;

  logic                          clk;
  logic                          rst;
  logic [0:UNITS-1]              unit_valid;
  logic [0:UNITS-1]              unit_ready;
  logic [0:UNITS-1][0:RSW-1]     unit_rs_id;
  logic [0:UNITS-1][0:4]         unit_reg_addr;
  logic [0:UNITS-1][0:31]        unit_result;
  cond_exception_t [0:UNITS-1]   unit_cr0_xer;
  logic                          cdb_valid;
  logic                          cdb_ready;
  logic [0:RSW-1]                cdb_rs_id;
  logic [0:4]                    cdb_reg_addr;
  logic [0:31]                   cdb_result;
  cond_exception_t               cdb_cr0_xer;
  logic [1:0]                    cdb_unit;
`ifdef CDB_PERF_CNT_EN
  logic [31:0]                   perf_grants;
  logic [31:0]                   perf_conflicts;
`endif

  cdb_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
    .clk           (clk),
    .rst           (rst),
    .unit_valid    (unit_valid),
    .unit_ready    (unit_ready),
    .unit_rs_id    (unit_rs_id),
    .unit_reg_addr (unit_reg_addr),
    .unit_result   (unit_result),
    .unit_cr0_xer  (unit_cr0_xer),
    .cdb_valid     (cdb_valid),
    .cdb_ready     (cdb_ready),
    .cdb_rs_id     (cdb_rs_id),
    .cdb_reg_addr  (cdb_reg_addr),
    .cdb_result    (cdb_result),
    .cdb_cr0_xer   (cdb_cr0_xer),
    .cdb_unit      (cdb_unit)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_grants   (perf_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed per-unit payloads; unit 2 carries the DEADBEEF result.
  logic [0:RSW-1]  tb_rs  [UNITS];
  logic [0:4]      tb_reg [UNITS];
  logic [0:31]     tb_res [UNITS];
  cond_exception_t tb_cr  [UNITS];

  // valid bits are written with unit 0 as the leftmost bit.
  typedef struct {
    logic           rst;
    logic [0:3]     valid;
    logic           rdy;
    int             exp_grant;   // -1: no unit_ready bit expected
    logic           exp_cv;
    int             exp_unit;
    logic           exp_zero;    // registered payload expected all zero
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic logic [0:3] onehot(input int i);
    logic [0:3] v;
    v = 4'b0000;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic add(input logic r, input logic [0:3] v, input logic rd,
                     input int eg, input logic ecv, input int eu, input logic ez);
    vec_t t;
    t.rst = r; t.valid = v; t.rdy = rd; t.exp_grant = eg;
    t.exp_cv = ecv; t.exp_unit = eu; t.exp_zero = ez;
    vecs.push_back(t);
  endtask

  task automatic check_vec(input int n, input vec_t t);
    if (unit_ready !== onehot(t.exp_grant)) begin
      n_bad++;
      $display("FAIL v%0d unit_ready got %b want %b", n, unit_ready, onehot(t.exp_grant));
    end
    if (cdb_valid !== t.exp_cv) begin
      n_bad++;
      $display("FAIL v%0d cdb_valid got %b want %b", n, cdb_valid, t.exp_cv);
    end
    if (t.exp_cv) begin
      if (cdb_unit !== 2'(t.exp_unit) || cdb_rs_id !== tb_rs[t.exp_unit] ||
          cdb_reg_addr !== tb_reg[t.exp_unit] || cdb_result !== tb_res[t.exp_unit] ||
          cdb_cr0_xer !== tb_cr[t.exp_unit]) begin
        n_bad++;
        $display("FAIL v%0d payload got unit=%0d rs=%0d reg=%0d res=%h cr=%b want unit=%0d rs=%0d reg=%0d res=%h cr=%b",
                 n, cdb_unit, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, t.exp_unit,
                 tb_rs[t.exp_unit], tb_reg[t.exp_unit], tb_res[t.exp_unit], tb_cr[t.exp_unit]);
      end
    end
    if (t.exp_zero) begin
      if (cdb_unit !== 2'd0 || cdb_rs_id !== 5'd0 || cdb_reg_addr !== 5'd0 ||
          cdb_result !== 32'd0 || cdb_cr0_xer !== 6'd0) begin
        n_bad++;
        $display("FAIL v%0d reset_payload got unit=%0d rs=%0d reg=%0d res=%h cr=%b want all 0",
                 n, cdb_unit, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer);
      end
    end
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_bad = 0;

    tb_rs[0] = 5'd1; tb_reg[0] = 5'd3;  tb_res[0] = 32'h1111_1111; tb_cr[0] = 6'b100001;
    tb_rs[1] = 5'd2; tb_reg[1] = 5'd4;  tb_res[1] = 32'h2222_2222; tb_cr[1] = 6'b010010;
    tb_rs[2] = 5'd5; tb_reg[2] = 5'd7;  tb_res[2] = 32'hDEAD_BEEF; tb_cr[2] = 6'b001100;
    tb_rs[3] = 5'd9; tb_reg[3] = 5'd10; tb_res[3] = 32'h3333_3333; tb_cr[3] = 6'b110101;
    for (int i = 0; i < UNITS; i++) begin
      unit_rs_id[i]    = tb_rs[i];
      unit_reg_addr[i] = tb_reg[i];
      unit_result[i]   = tb_res[i];
      unit_cr0_xer[i]  = tb_cr[i];
    end

    rst        = 1'b1;
    unit_valid = 4'b1111;
    cdb_ready  = 1'b1;
    repeat (2) @(posedge clk);

    //   rst   valid    rdy   grant cv    unit zero
    add(1'b1, 4'b1111, 1'b1, -1, 1'b0, 0, 1'b1);  // in reset: nothing ready, outputs zero
    add(1'b0, 4'b1111, 1'b1,  0, 1'b0, 0, 1'b0);  // first cycle out of reset: unit 0
    add(1'b0, 4'b1111, 1'b1,  1, 1'b1, 0, 1'b0);
    add(1'b0, 4'b1111, 1'b1,  2, 1'b1, 1, 1'b0);
    add(1'b0, 4'b1111, 1'b1,  3, 1'b1, 2, 1'b0);
    add(1'b0, 4'b1111, 1'b1,  0, 1'b1, 3, 1'b0);  // wrap back to unit 0, no gap
    add(1'b0, 4'b1111, 1'b1,  1, 1'b1, 0, 1'b0);
    add(1'b0, 4'b0010, 1'b1,  2, 1'b1, 1, 1'b0);  // only unit 2
    add(1'b0, 4'b0000, 1'b1, -1, 1'b1, 2, 1'b0);  // unit 2 payload on the CDB
    add(1'b0, 4'b0000, 1'b1, -1, 1'b0, 0, 1'b0);  // drained, nothing new
    add(1'b0, 4'b0100, 1'b1,  1, 1'b0, 0, 1'b0);  // single requester, pointer at 3
    add(1'b0, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);  // back-pressure cycle 1
    add(1'b0, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);  // back-pressure cycle 2
    add(1'b0, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);  // back-pressure cycle 3
    add(1'b0, 4'b0101, 1'b1,  3, 1'b1, 1, 1'b0);  // drain + refill, pointer 2 -> unit 3
    add(1'b0, 4'b0101, 1'b1,  1, 1'b1, 3, 1'b0);  // pointer 0 -> unit 1
    add(1'b0, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);  // held, pointer now 2
    add(1'b1, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);  // reset during hold
    add(1'b0, 4'b0101, 1'b0,  1, 1'b0, 0, 1'b1);  // entry gone, pointer 0 -> unit 1
    add(1'b0, 4'b0101, 1'b0, -1, 1'b1, 1, 1'b0);
    add(1'b0, 4'b0000, 1'b1, -1, 1'b1, 1, 1'b0);
    add(1'b0, 4'b0000, 1'b1, -1, 1'b0, 0, 1'b0);
    add(1'b0, 4'b1001, 1'b1,  3, 1'b0, 0, 1'b0);  // pointer 2 -> unit 3
    add(1'b0, 4'b1001, 1'b1,  0, 1'b1, 3, 1'b0);  // pointer 0 -> unit 0
    add(1'b0, 4'b1001, 1'b1,  3, 1'b1, 0, 1'b0);  // pointer 1 -> unit 3
    add(1'b0, 4'b0000, 1'b1, -1, 1'b1, 3, 1'b0);
    add(1'b0, 4'b0000, 1'b1, -1, 1'b0, 0, 1'b0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      rst        = vecs[n].rst;
      unit_valid = vecs[n].valid;
      cdb_ready  = vecs[n].rdy;
      #1;
      n_vec++;
      check_vec(n, vecs[n]);
    end

    // Starvation: unit 3 continuously valid with everyone else, pointer reset to 0.
    @(negedge clk);
    rst = 1'b1; unit_valid = 4'b1111; cdb_ready = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 1; c <= UNITS && seen == 0; c++) begin
      #1;
      if (unit_ready[3] === 1'b1) seen = c;
      @(negedge clk);
    end
    n_vec++;
    if (seen != UNITS) begin
      n_bad++;
      $display("FAIL starvation unit3 granted at load cycle %0d want %0d", seen, UNITS);
    end

`ifdef CDB_PERF_CNT_EN
    // Ten load cycles with three contenders: ten grants, ten conflicts.
    rst = 1'b1; unit_valid = 4'b1110; cdb_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (perf_grants !== 32'd0 || perf_conflicts !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset got grants=%0d conflicts=%0d want 0 0", perf_grants, perf_conflicts);
    end
    repeat (10) @(negedge clk);
    #1;
    n_vec++;
    if (perf_grants !== 32'd10 || perf_conflicts !== 32'd10) begin
      n_bad++;
      $display("FAIL perf_count got grants=%0d conflicts=%0d want 10 10", perf_grants, perf_conflicts);
    end
`endif

    @(negedge clk);
    unit_valid = 4'b0000;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
